net_batch_runner: RTL and testbench

NET_BATCH_RUNNER -- requirements
Module: net_batch_runner

---
 rtl/net_batch_runner.sv | 136 +++++++++++++
 tb/tb_net_batch_runner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/net_batch_runner.sv
// net_batch_runner: Avalon-MM batch runner that feeds {A,B} pairs to a combinational network core and queues its results
// Optional feature: define NET_BATCH_CYCLE_COUNT_EN to add a busy-cycle counter at address 5
// Ports:
//   clk, reset (sync, active-high)
//   avs_s0_address/read/write/writedata/readdata : register slave (0 a_hold, 1 push pair, 2 pop result,
//                                                  3 status/control, 4 done_count, 5 busy-cycle count)
//   net_in  : registered {A,B} operand pair to the network core
//   net_out : network core result, combinational from net_in
//   busy    : high whenever the sequencer is not idle
module net_batch_runner #(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  avs_s0_address,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    output logic [31:0] avs_s0_readdata,
    output logic [63:0] net_in,
    input  logic [31:0] net_out,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_CAPTURE} state_t;
    state_t state;
    logic [63:0] in_mem [DEPTH];
    logic [31:0] res_mem [DEPTH];
    logic [AW-1:0] in_wp, in_rp, res_wp, res_rp;
    logic [6:0] in_count, res_count, in_count_n;
    logic [31:0] a_hold, done_count, rd;
    logic [3:0] settle_cnt;
    logic run, ovf, udf;
    logic wr_a, wr_b, wr_ctl, rd_res, in_full, res_full, res_empty;
    logic in_push, in_pop, res_push, res_pop;
    assign wr_a      = avs_s0_write && avs_s0_address == 4'd0;
    assign wr_b      = avs_s0_write && avs_s0_address == 4'd1;
    assign wr_ctl    = avs_s0_write && avs_s0_address == 4'd3;
    assign rd_res    = avs_s0_read && avs_s0_address == 4'd2;
    assign in_full   = in_count == 7'(DEPTH);
    assign res_full  = res_count == 7'(DEPTH);
    assign res_empty = res_count == 7'd0;
    assign res_pop   = rd_res && !res_empty;
    // A result pop in the same cycle frees the slot the capture needs
    assign res_push  = state == S_CAPTURE && (!res_full || res_pop);
    assign in_pop    = res_push;
    assign in_push   = wr_b && (!in_full || in_pop);
    assign in_count_n = in_count + 7'(in_push) - 7'(in_pop);
    assign busy = state != S_IDLE;
`ifdef NET_BATCH_CYCLE_COUNT_EN
    logic [31:0] cyc_count;
    always_ff @(posedge clk) begin
        if (reset || (avs_s0_write && avs_s0_address == 4'd5))
            cyc_count <= '0;
        else if (busy)
            cyc_count <= cyc_count + 32'd1;
    end
`endif
    always_comb begin
        rd = '0;
        case (avs_s0_address)
            4'd2: rd = res_empty ? 32'd0 : res_mem[res_rp];
            4'd3: rd = {16'b0, res_count, in_count, udf, ovf};
            4'd4: rd = done_count;
`ifdef NET_BATCH_CYCLE_COUNT_EN
            4'd5: rd = cyc_count;
`endif
            default: rd = '0;
        endcase
    end
    assign avs_s0_readdata = avs_s0_read ? rd : 32'd0;
    // Storage arrays carry no reset; validity is tracked by the pointers and counts
    always_ff @(posedge clk) begin
        if (in_push)
            in_mem[in_wp] <= {a_hold, avs_s0_writedata};
        if (res_push)
            res_mem[res_wp] <= net_out;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            in_wp      <= '0;
            in_rp      <= '0;
            res_wp     <= '0;
            res_rp     <= '0;
            in_count   <= '0;
            res_count  <= '0;
            a_hold     <= '0;
            net_in     <= '0;
            done_count <= '0;
            settle_cnt <= '0;
            run        <= 1'b0;
            ovf        <= 1'b0;
            udf        <= 1'b0;
        end else begin
            if (wr_a)
                a_hold <= avs_s0_writedata;
            if (in_push)
                in_wp <= in_wp + 1'b1;
            if (in_pop)
                in_rp <= in_rp + 1'b1;
            in_count <= in_count_n;
            if (res_push) begin
                res_wp     <= res_wp + 1'b1;
                done_count <= done_count + 32'd1;
            end
            if (res_pop)
                res_rp <= res_rp + 1'b1;
            res_count <= res_count + 7'(res_push) - 7'(res_pop);
            if (wr_ctl)
                run <= (run | avs_s0_writedata[0]) & ~avs_s0_writedata[2];
            // A new error event in the same cycle as a clear still leaves the flag set
            ovf <= (ovf & ~(wr_ctl & avs_s0_writedata[1])) | (wr_b & in_full & ~in_pop);
            udf <= (udf & ~(wr_ctl & avs_s0_writedata[1])) | (rd_res & res_empty);
            case (state)
                S_IDLE:
                    if (run && in_count != 7'd0)
                        state <= S_LOAD;
                S_LOAD: begin
                    net_in     <= in_mem[in_rp];
                    settle_cnt <= 4'(SETTLE - 1);
                    state      <= S_SETTLE;
                end
                S_SETTLE:
                    if (settle_cnt == 4'd0)
                        state <= S_CAPTURE;
                    else
                        settle_cnt <= settle_cnt - 4'd1;
                default:
                    if (res_push)
                        state <= (run && in_count_n != 7'd0) ? S_LOAD : S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_net_batch_runner.sv
// tb_net_batch_runner: scoreboard bench for net_batch_runner with an A+B network core model
module tb_net_batch_runner;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic [31:0] avs_s0_readdata;
    logic [63:0] net_in;
    logic [31:0] net_out;
    logic        busy;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    net_batch_runner dut (
        .clk(clk),
        .reset(reset),
        .avs_s0_address(avs_s0_address),
        .avs_s0_read(avs_s0_read),
        .avs_s0_write(avs_s0_write),
        .avs_s0_writedata(avs_s0_writedata),
        .avs_s0_readdata(avs_s0_readdata),
        .net_in(net_in),
        .net_out(net_out),
        .busy(busy)
    );

    assign net_out = net_in[63:32] + net_in[31:0];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (avs_s0_read) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: addr %0d got %0h required none", avs_s0_address, avs_s0_readdata);
            end else begin
                logic [31:0] e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (avs_s0_readdata !== e) begin
                    errors++;
                    $display("FAIL %s: got %0h required %0h", n, avs_s0_readdata, e);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", n, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        avs_s0_address = a;
        avs_s0_writedata = d;
        avs_s0_write = 1'b1;
        @(posedge clk); #1;
        avs_s0_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        avs_s0_address = a;
        avs_s0_read = 1'b1;
        @(posedge clk); #1;
        avs_s0_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cyc_exp;
`ifdef NET_BATCH_CYCLE_COUNT_EN
        cyc_exp = 32'd4;
`else
        cyc_exp = 32'd0;
`endif
        reset = 1'b1;
        avs_s0_address = '0;
        avs_s0_read = 1'b0;
        avs_s0_write = 1'b0;
        avs_s0_writedata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_net_in", net_in, 64'd0);
        rd(4'd3, 32'd0, "reset_status");
        rd(4'd4, 32'd0, "reset_done");
        // single pair 3+4
        wr(4'd0, 32'd3);
        wr(4'd1, 32'd4);
        wr(4'd3, 32'd1);
        idle(10);
        rd(4'd2, 32'd7, "single_result");
        rd(4'd4, 32'd1, "single_done");
        rd(4'd3, 32'd0, "single_status");
        chk("single_busy", {63'd0, busy}, 64'd0);
        chk("single_net_in_held", net_in, {32'd3, 32'd4});
        rd(4'd5, cyc_exp, "busy_cycles");
        wr(4'd5, 32'd0);
        rd(4'd5, 32'd0, "busy_cycles_cleared");
        wr(4'd7, 32'd55);
        rd(4'd7, 32'd0, "unmapped");
        // overflow with run cleared
        wr(4'd3, 32'd4);
        wr(4'd0, 32'd100);
        for (int i = 0; i < 9; i++) wr(4'd1, 32'(i));
        rd(4'd3, 32'd33, "ovf_status");
        wr(4'd3, 32'd2);
        rd(4'd3, 32'd32, "ovf_cleared");
        // underflow
        rd(4'd2, 32'd0, "udf_read");
        rd(4'd3, 32'd34, "udf_status");
        wr(4'd3, 32'd2);
        rd(4'd3, 32'd32, "udf_cleared");
        // ten pairs, result FIFO fills and the sequencer stalls in CAPTURE
        wr(4'd3, 32'd1);
        idle(12);
        wr(4'd1, 32'd8);
        wr(4'd1, 32'd9);
        idle(40);
        chk("stall_busy", {63'd0, busy}, 64'd1);
        chk("stall_net_in", net_in, {32'd100, 32'd8});
        rd(4'd3, 32'd4104, "stall_status");
        rd(4'd2, 32'd100, "stall_pop");
        rd(4'd3, 32'd4100, "stall_released");
        for (int i = 1; i < 10; i++) rd(4'd2, 32'd100 + 32'(i), $sformatf("drain_%0d", i));
        idle(3);
        rd(4'd4, 32'd11, "batch_done");
        rd(4'd3, 32'd0, "batch_status");
        chk("batch_busy", {63'd0, busy}, 64'd0);
        avs_s0_address = 4'd4;
        #1 chk("readdata_no_read", {32'd0, avs_s0_readdata}, 64'd0);
        // reset during SETTLE
        wr(4'd0, 32'd5);
        wr(4'd1, 32'd6);
        idle(2);
        chk("settle_busy", {63'd0, busy}, 64'd1);
        chk("settle_net_in", net_in, {32'd5, 32'd6});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_reset_busy", {63'd0, busy}, 64'd0);
        chk("mid_reset_net_in", net_in, 64'd0);
        rd(4'd3, 32'd0, "mid_reset_status");
        rd(4'd4, 32'd0, "mid_reset_done");
        rd(4'd5, 32'd0, "mid_reset_cycles");
        idle(8);
        chk("post_reset_busy", {63'd0, busy}, 64'd0);
        rd(4'd3, 32'd0, "post_reset_status");
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
